// File: rtl/pcie_phy_pkg.sv
// Shared PHY definitions: ordered-set type codes, 8b/10b symbol constants,
// set lengths, the generator FSM state type and small symbol helpers.
package pcie_phy_pkg;

  typedef enum logic [2:0] {
    OS_TS1  = 3'b000,
    OS_TS2  = 3'b001,
    OS_SKP  = 3'b010,
    OS_EIOS = 3'b011,
    OS_IDLE = 3'b100
  } os_type_e;

  typedef enum logic {
    IDLE_S = 1'b0,
    SEND   = 1'b1
  } os_state_e;

  localparam logic [7:0] K_COM  = 8'hBC;
  localparam logic [7:0] K_PAD  = 8'hF7;
  localparam logic [7:0] K_SKP  = 8'h1C;
  localparam logic [7:0] K_IDL  = 8'h7C;
  localparam logic [7:0] TS1_ID = 8'h4A;
  localparam logic [7:0] TS2_ID = 8'h45;

  localparam int TS_LEN   = 16;
  localparam int SKP_LEN  = 4;
  localparam int EIOS_LEN = 4;
  localparam int IDX_W    = 8;

  // Index of the final symbol of a set; IDLE length is a block parameter.
  function automatic logic [IDX_W-1:0] os_last(input os_type_e t, input int idle_len);
    int len;
    case (t)
      OS_TS1, OS_TS2: len = TS_LEN;
      OS_SKP:         len = SKP_LEN;
      OS_EIOS:        len = EIOS_LEN;
      default:        len = idle_len;
    endcase
    return IDX_W'(len - 1);
  endfunction

  // TS rate identifier: one bit per supported rate from bit 1 upward.
  function automatic logic [7:0] rate_byte(input logic [2:0] rate, input int max_gen);
    int r;
    logic [7:0] b;
    r = int'(rate);
    if (r > max_gen) r = max_gen;
    if (r < 1) r = 1;
    b = '0;
    for (int i = 1; i < 8; i++) b[i] = (i <= r);
    return b;
  endfunction

endpackage

// File: rtl/os_symbol_lut.sv
// Combinational symbol table: returns the {data, K} pair for one lane at a
// given position within a TS1/TS2/SKP/EIOS/IDLE ordered set.
import pcie_phy_pkg::*;

module os_symbol_lut #(
  parameter int         MAX_GEN = 1,
  parameter logic [7:0] N_FTS   = 8'hFF
) (
  input  os_type_e               os_type,
  input  logic [IDX_W-1:0]       index,
  input  logic [7:0]             link,
  input  logic [1:0]             lane_mode,
  input  logic [7:0]             lane,
  input  logic [2:0]             rate,
  input  logic                   loopback,
  output logic [7:0]             data,
  output logic                   k
);

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    data = 8'h00;
    k    = 1'b0;
    case (os_type)
      OS_TS1, OS_TS2: begin
        case (index)
          8'd0: begin data = K_COM; k = 1'b1; end
          8'd1: begin
            if (link == 8'h00) begin data = K_PAD; k = 1'b1; end
            else               data = link;
          end
          8'd2: begin
            if (lane_mode == 2'b01) data = lane;
            else begin data = K_PAD; k = 1'b1; end
          end
          8'd3:    data = N_FTS;
          8'd4:    data = rate_byte(rate, MAX_GEN);
          8'd5:    data = {5'b0, loopback, 2'b0};
          default: data = (os_type == OS_TS1) ? TS1_ID : TS2_ID;
        endcase
      end
      OS_SKP: begin
        data = (index == '0) ? K_COM : K_SKP;
        k    = 1'b1;
      end
      OS_EIOS: begin
        data = (index == '0) ? K_COM : K_IDL;
        k    = 1'b1;
      end
      default: begin
        data = 8'h00;
        k    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/tx_os_generator.sv
// TX ordered-set generator: FSM, symbol index, registered per-lane outputs.
// Define OSGEN_SKP_EN to add periodic SKP insertion ahead of requested sets.
import pcie_phy_pkg::*;

module tx_os_generator #(
  parameter int         LANESNUMBER  = 16,
  parameter int         MAX_GEN      = 1,
  parameter logic [7:0] N_FTS        = 8'hFF,
  parameter int         IDLE_LEN     = 16,
  parameter int         SKP_INTERVAL = 1180
) (
  input  logic                       Pclk,
  input  logic                       Reset,
  input  logic                       OSGeneratorStart,
  input  logic [2:0]                 OSType,
  input  logic [1:0]                 LaneNumber,
  input  logic [7:0]                 LinkNumber,
  input  logic [2:0]                 Rate,
  input  logic                       Loopback,
  output logic                       OSGeneratorBusy,
  output logic                       OSGeneratorFinish,
  output logic [8*LANESNUMBER-1:0]   TxData,
  output logic [LANESNUMBER-1:0]     TxDataK,
  output logic                       TxDataValid
);

  os_state_e        state, state_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic             skp_phase, skp_phase_n;
  os_type_e         lat_type, lat_type_n, cur_type, next_type;
  logic [7:0]       lat_link, lat_link_n;
  logic [1:0]       lat_lane_mode, lat_lane_mode_n;
  logic [2:0]       lat_rate, lat_rate_n;
  logic             lat_loopback, lat_loopback_n;
  logic             accept, skp_due, finish_n, valid_n;
  logic [7:0]       lut_data [LANESNUMBER];
  logic             lut_k    [LANESNUMBER];

`ifdef OSGEN_SKP_EN
  localparam int TW = $clog2(SKP_INTERVAL + 1);
  logic [TW-1:0] skp_timer;

  assign skp_due = (skp_timer == TW'(SKP_INTERVAL));

  // Timer restarts whenever a SKP set begins, inserted or explicitly requested.
  always_ff @(posedge Pclk) begin
    if (!Reset)
      skp_timer <= '0;
    else if (accept && (skp_due || OSType == 3'(OS_SKP)))
      skp_timer <= '0;
    else if (!skp_due)
      skp_timer <= skp_timer + 1'b1;
  end
`else
  assign skp_due = 1'b0;
`endif

  assign accept = (state == IDLE_S) && OSGeneratorStart && (OSType <= 3'(OS_IDLE));

  always_comb begin
    state_n         = state;
    idx_n           = idx;
    skp_phase_n     = skp_phase;
    lat_type_n      = lat_type;
    lat_link_n      = lat_link;
    lat_lane_mode_n = lat_lane_mode;
    lat_rate_n      = lat_rate;
    lat_loopback_n  = lat_loopback;
    cur_type        = skp_phase ? OS_SKP : lat_type;
    case (state)
      IDLE_S: begin
        if (accept) begin
          state_n         = SEND;
          idx_n           = '0;
          skp_phase_n     = skp_due && (OSType != 3'(OS_SKP));
          lat_type_n      = os_type_e'(OSType);
          lat_link_n      = LinkNumber;
          lat_lane_mode_n = LaneNumber;
          lat_rate_n      = Rate;
          lat_loopback_n  = Loopback;
        end
      end
      SEND: begin
        if (idx == os_last(cur_type, IDLE_LEN)) begin
          idx_n = '0;
          if (skp_phase) skp_phase_n = 1'b0;
          else           state_n     = IDLE_S;
        end else begin
          idx_n = idx + 1'b1;
        end
      end
      default: state_n = IDLE_S;
    endcase
    // Outputs are registered, so the table is addressed with next-cycle values.
    next_type = skp_phase_n ? OS_SKP : lat_type_n;
    valid_n   = (state_n == SEND);
    finish_n  = valid_n && !skp_phase_n && (idx_n == os_last(next_type, IDLE_LEN));
  end

  for (genvar g = 0; g < LANESNUMBER; g++) begin : g_lane
    os_symbol_lut #(
      .MAX_GEN (MAX_GEN),
      .N_FTS   (N_FTS)
    ) u_lut (
      .os_type   (next_type),
      .index     (idx_n),
      .link      (lat_link_n),
      .lane_mode (lat_lane_mode_n),
      .lane      (8'(g)),
      .rate      (lat_rate_n),
      .loopback  (lat_loopback_n),
      .data      (lut_data[g]),
      .k         (lut_k[g])
    );
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge Pclk) begin
    if (!Reset) begin
      state             <= IDLE_S;
      idx               <= '0;
      skp_phase         <= 1'b0;
      lat_type          <= OS_TS1;
      lat_link          <= '0;
      lat_lane_mode     <= '0;
      lat_rate          <= '0;
      lat_loopback      <= 1'b0;
      OSGeneratorBusy   <= 1'b0;
      OSGeneratorFinish <= 1'b0;
      TxDataValid       <= 1'b0;
      TxData            <= '0;
      TxDataK           <= '0;
    end else begin
      state             <= state_n;
      idx               <= idx_n;
      skp_phase         <= skp_phase_n;
      lat_type          <= lat_type_n;
      lat_link          <= lat_link_n;
      lat_lane_mode     <= lat_lane_mode_n;
      lat_rate          <= lat_rate_n;
      lat_loopback      <= lat_loopback_n;
      OSGeneratorBusy   <= valid_n;
      OSGeneratorFinish <= finish_n;
      TxDataValid       <= valid_n;
      for (int i = 0; i < LANESNUMBER; i++) begin
        TxData[8*i +: 8] <= valid_n ? lut_data[i] : 8'h00;
        TxDataK[i]       <= valid_n & lut_k[i];
      end
    end
  end

endmodule
